// File: rtl/execute_multilane.sv
`default_nettype none
// ----------------------------------------------------------------------------
// execute_multilane : LANES-wide execute stage, single-cycle ALU or RV32M lanes
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module execute_multilane #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [LANES-1:0]            LaneEn_i,
  input  logic [4*LANES-1:0]          ALUCtrl_i,
  input  logic [LANES-1:0]            ALUSrcB_i,
  input  logic [LANES-1:0]            MulDiv_i,
  input  logic [3*LANES-1:0]          MDOp_i,
  input  logic [DATA_WIDTH*LANES-1:0] RD1_i,
  input  logic [DATA_WIDTH*LANES-1:0] RD2_i,
  input  logic [DATA_WIDTH*LANES-1:0] ImmExt_i,
  output logic                        valid_o,
  output logic [LANES-1:0]            LaneValid_o,
  output logic [DATA_WIDTH*LANES-1:0] ALUResult_o
);
  localparam int DW = DATA_WIDTH;
  localparam int SW = $clog2(DW);
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] ITERS    = CW'(DW);
  localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // ALU encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, A pass B
  function automatic logic [DW-1:0] alu(input logic [3:0] ctrl, input logic [DW-1:0] a, b);
    logic [DW-1:0] r;
    case (ctrl)
      4'h0:    r = a + b;
      4'h1:    r = a - b;
      4'h2:    r = a & b;
      4'h3:    r = a | b;
      4'h4:    r = a ^ b;
      4'h5:    r = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      4'h6:    r = {{(DW-1){1'b0}}, (a < b)};
      4'h7:    r = a << b[SW-1:0];
      4'h8:    r = a >> b[SW-1:0];
      4'h9:    r = $unsigned($signed(a) >>> b[SW-1:0]);
      4'hA:    r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] mul(input logic [2:0] op, input logic [DW-1:0] a, b);
    logic [2*DW-1:0] ax, bx, p;
    ax = {{DW{a[DW-1] & (op[1:0] != 2'b11)}}, a};
    bx = {{DW{b[DW-1] & (op[1:0] == 2'b01)}}, b};
    p  = ax * bx;
    return (op[1:0] == 2'b00) ? p[DW-1:0] : p[2*DW-1:DW];
  endfunction

  // Divide-by-zero and signed overflow bypass the iterative divider
  function automatic logic special(input logic [2:0] op, input logic [DW-1:0] a, b);
    return (b == '0) | (~op[0] & (a == MOST_NEG) & (b == '1));
  endfunction

  function automatic logic [DW-1:0] special_res(input logic [2:0] op, input logic [DW-1:0] a, b);
    if (b == '0) return op[1] ? a : '1;
    return op[1] ? '0 : a;
  endfunction

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [LANES-1:0] en_q, md_q, neg_q, neg_r;
  logic [2:0]       op_q   [LANES];
  logic [DW-1:0]    a_q    [LANES];
  logic [DW-1:0]    b_q    [LANES];
  logic [DW-1:0]    bmag_q [LANES];
  logic [DW-1:0]    alu_q  [LANES];
  logic [DW-1:0]    quo    [LANES];
  logic [DW-1:0]    rem    [LANES];

  logic [DW-1:0]    alu_in  [LANES];
  logic [DW-1:0]    amag_in [LANES];
  logic [DW-1:0]    bmag_in [LANES];
  logic [DW-1:0]    quo_nx  [LANES];
  logic [DW-1:0]    rem_nx  [LANES];
  logic [DW-1:0]    res_fin [LANES];
  logic [LANES-1:0] nq_in, nr_in, long_l;
  logic             accept, need_md, done;

  assign ready_o = (state == IDLE);
  assign accept  = valid_i & ready_o & ~flush_i;
  assign need_md = |(LaneEn_i & MulDiv_i);
  assign done    = ~(|long_l) | (cnt == ITERS);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DW-1:0] rd1, rd2, opb;
    logic [DW:0]   trial;
    logic          sgn;

    assign rd1        = RD1_i[k*DW +: DW];
    assign rd2        = RD2_i[k*DW +: DW];
    assign opb        = ALUSrcB_i[k] ? ImmExt_i[k*DW +: DW] : rd2;
    assign alu_in[k]  = alu(ALUCtrl_i[4*k +: 4], rd1, opb);
    assign sgn        = ~MDOp_i[3*k];
    assign amag_in[k] = (sgn & rd1[DW-1]) ? -rd1 : rd1;
    assign bmag_in[k] = (sgn & rd2[DW-1]) ? -rd2 : rd2;
    assign nq_in[k]   = sgn & (rd1[DW-1] ^ rd2[DW-1]);
    assign nr_in[k]   = sgn & rd1[DW-1];
    assign long_l[k]  = en_q[k] & md_q[k] & op_q[k][2] & ~special(op_q[k], a_q[k], b_q[k]);

    // One restoring step: shift in the next dividend bit, subtract if it fits
    assign trial     = {rem[k], quo[k][DW-1]} - {1'b0, bmag_q[k]};
    assign rem_nx[k] = trial[DW] ? {rem[k][DW-2:0], quo[k][DW-1]} : trial[DW-1:0];
    assign quo_nx[k] = {quo[k][DW-2:0], ~trial[DW]};

    assign res_fin[k] = !md_q[k]                          ? alu_q[k] :
                        !op_q[k][2]                        ? mul(op_q[k], a_q[k], b_q[k]) :
                        special(op_q[k], a_q[k], b_q[k])   ? special_res(op_q[k], a_q[k], b_q[k]) :
                        op_q[k][1]                         ? (neg_r[k] ? -rem[k] : rem[k]) :
                                                             (neg_q[k] ? -quo[k] : quo[k]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      valid_o     <= 1'b0;
      LaneValid_o <= '0;
      ALUResult_o <= '0;
      en_q        <= '0;
      md_q        <= '0;
      neg_q       <= '0;
      neg_r       <= '0;
      for (int k = 0; k < LANES; k++) begin
        op_q[k]   <= '0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        bmag_q[k] <= '0;
        alu_q[k]  <= '0;
        quo[k]    <= '0;
        rem[k]    <= '0;
      end
    end else begin
      valid_o     <= 1'b0;
      LaneValid_o <= '0;
      case (state)
        IDLE: begin
          if (accept && need_md) begin
            state <= BUSY;
            cnt   <= '0;
            en_q  <= LaneEn_i;
            md_q  <= MulDiv_i;
            neg_q <= nq_in;
            neg_r <= nr_in;
            for (int k = 0; k < LANES; k++) begin
              op_q[k]   <= MDOp_i[3*k +: 3];
              a_q[k]    <= RD1_i[k*DW +: DW];
              b_q[k]    <= RD2_i[k*DW +: DW];
              bmag_q[k] <= bmag_in[k];
              alu_q[k]  <= alu_in[k];
              quo[k]    <= amag_in[k];
              rem[k]    <= '0;
            end
          end else if (accept) begin
            valid_o     <= 1'b1;
            LaneValid_o <= LaneEn_i;
            for (int k = 0; k < LANES; k++)
              if (LaneEn_i[k]) ALUResult_o[k*DW +: DW] <= alu_in[k];
          end
        end
        BUSY: begin
          if (flush_i) begin
            state <= IDLE;
          end else if (done) begin
            state       <= IDLE;
            valid_o     <= 1'b1;
            LaneValid_o <= en_q;
            for (int k = 0; k < LANES; k++)
              if (en_q[k]) ALUResult_o[k*DW +: DW] <= res_fin[k];
          end else begin
            cnt <= cnt + CW'(1);
            for (int k = 0; k < LANES; k++) begin
              quo[k] <= quo_nx[k];
              rem[k] <= rem_nx[k];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: doc/execute_multilane.md
Name: execute_multilane

Overview:
- Parametrised successor to the dual-issue execute stage: LANES parallel execute lanes with a registered output stage.
- Each lane runs either a single-cycle ALU op (existing ALU module, 4-bit ALUCtrl) or an RV32M-style multiply/divide op.
- Sits between the decode/register-read stage and the memory stage.
- Bundle-level valid/ready handshake; stalls upstream while multi-cycle ops are in flight.

Parameters:
- DATA_WIDTH, 32, operand/result width (even, >=8).
- LANES, 2, number of execute lanes (>=1).

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  abort in-flight bundle (sync).
- valid_i  in  1  input bundle valid.
- ready_o  out  1  stage can accept a bundle this cycle.
- LaneEn_i  in  LANES  per-lane instruction present.
- ALUCtrl_i  in  4*LANES  per-lane ALU control; lane k = [4k+:4].
- ALUSrcB_i  in  LANES  1 = ImmExt as operand B, 0 = RD2.
- MulDiv_i  in  LANES  1 = lane executes MDOp instead of ALU op.
- MDOp_i  in  3*LANES  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- RD1_i, RD2_i, ImmExt_i  in  DATA_WIDTH*LANES each  lane k = [k*DATA_WIDTH+:DATA_WIDTH].
- valid_o  out  1  one-cycle pulse: results of a bundle available.
- LaneValid_o  out  LANES  LaneEn of the retiring bundle, qualified by valid_o.
- ALUResult_o  out  DATA_WIDTH*LANES  registered per-lane results.

Behaviour:
- Reset (rst_i=1 at edge): state IDLE, valid_o=0, LaneValid_o=0, ALUResult_o=0, ready_o=1 after reset.
- Operand B per lane = ALUSrcB ? ImmExt : RD2. MUL/DIV ops always use RD1, RD2 (ALUSrcB ignored when MulDiv=1).
- Accept when valid_i & ready_o. ready_o = (state==IDLE). Combinational from state only; no valid_i→ready_o path.
- FSM IDLE/BUSY:
  - IDLE, accept, no enabled lane with MulDiv=1: register all ALU results; valid_o=1 next cycle; stay IDLE (throughput 1 bundle/cycle).
  - IDLE, accept, >=1 enabled MulDiv lane: latch operands/controls, go BUSY. ALU-lane results are held internally until retire.
  - BUSY→IDLE when every enabled MulDiv lane is done; ALUResult_o updates and valid_o pulses on that same edge.
- Latency, edge of acceptance = cycle 0:
  - ALU: 1.
  - MUL*: 2 (one internal register stage).
  - DIV/REM: DATA_WIDTH+2. Restoring iterative divider on magnitudes, 1 bit/cycle, sign fix-up on the final cycle.
  - Bundle latency = max over its enabled lanes.
- Arithmetic:
  - MUL returns low DATA_WIDTH bits of the product. MULH/MULHSU/MULHU return high bits (signed×signed, signed×unsigned, unsigned×unsigned).
  - Divide by zero: DIV/DIVU = all ones, REM/REMU = dividend.
  - Signed overflow (most-negative / -1): DIV = dividend, REM = 0.
  - Both special cases complete at latency 2, not the full iteration.
- Disabled lanes (LaneEn=0): result slot holds its previous value; LaneValid bit 0. A bundle with LaneEn all zero is still accepted and retires at latency 1 with LaneValid_o=0.
- Outputs hold between retires; valid_o is never high for 2 consecutive cycles while BUSY.
- flush_i:
  - Same cycle as an accept: the bundle is dropped.
  - While BUSY: return to IDLE next edge, abort dividers/multipliers, no valid_o. ALUResult_o keeps its prior value.
  - Suppresses a retire occurring on the same edge.
  - rst_i has priority over flush_i.
- Reset mid-operation: all in-flight work discarded, outputs to reset values.

Test Plan:
- ALU-only, LANES=2: valid_i with lane0 ADD 5+7, lane1 ALUSrcB=1 imm 0x10 + 3 on consecutive cycles → valid_o each cycle after 1-cycle latency; results 12, 0x13; ready_o stays 1.
- Mixed bundle: lane0 MUL 0xFFFFFFFF×2, lane1 ADD 1+1 → ready_o low for 1 cycle; valid_o at cycle 2 with 0xFFFFFFFE, 2. Same operands with MULHU → 1; with MULH → 0xFFFFFFFF.
- Divide: lane0 DIV -20/3 → valid_o at cycle 34 (DATA_WIDTH=32) with 0xFFFFFFFA; REM → 0xFFFFFFFE; ready_o low cycles 1–33; valid_i held high meanwhile is not accepted.
- Special cases: DIVU 9/0 → 0xFFFFFFFF at cycle 2; REM 0x80000000/-1 → 0 at cycle 2; DIV 0x80000000/-1 → 0x80000000.
- flush_i asserted at cycle 10 of a DIV → no valid_o, ready_o=1 at cycle 11, next ADD bundle retires normally. rst_i at cycle 5 of a DIV → all outputs 0 next cycle.
- Re-parametrise LANES=4, DATA_WIDTH=16: LaneEn=0101, lanes 0/2 DIVU 100/7 and SUB → valid_o at cycle 18, LaneValid_o=0101, lane0=14, lane1/3 slots unchanged.
